line_window3x3: RTL and testbench
=================================

LINE_WINDOW3X3 -- requirements
Module: line_window3x3

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 640: maximum supported line length in pixels.
REQ-002 SHALL have parameter ADDR_W, default 10: line-buffer address width; SHALL satisfy 2**ADDR_W >= MAX_WIDTH.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port width  input  16  frame width in pixels, as produced by the parse stage; sampled only on sof.
REQ-006 SHALL have port sof  input  1  start-of-frame strobe, one cycle, at or before the first pixel of a frame.
REQ-007 SHALL have port pix_in  input  8  grayscale pixel from rgb2gray, raster order.
REQ-008 SHALL have port pix_valid  input  1  pix_in is accepted on every cycle where this is high; no backpressure exists.
REQ-009 SHALL have port win  output  72  3x3 window; byte k = win[8k+7:8k], k = 3*r + c, r=0 top row (y-2), c=0 left column (x-2).
REQ-010 SHALL have port win_valid  output  1  win, cx and cy are valid this cycle.
REQ-011 SHALL have port cx  output  16  window centre column.
REQ-012 SHALL have port cy  output  16  window centre row.
REQ-013 SHALL have port cfg_err  output  1  latched width is unusable.

Function
REQ-014 SHALL hold two line buffers of MAX_WIDTH x 8 bits: LB1 holds row y-1, LB2 holds row y-2.
REQ-015 SHALL keep column counter col and row counter row, both 16 bits, giving the position of the next accepted pixel.
REQ-016 On sof, SHALL latch width into wreg, clear col and row, and set cfg_err = (width < 3) or (width > MAX_WIDTH).
REQ-017 SHALL accept pixel (col,row) on each cycle with pix_valid=1; while cfg_err=1, pixels SHALL be ignored and no counters SHALL move.
REQ-018 Per accepted pixel, SHALL read LB1[col] and LB2[col], write pix_in to LB1[col], and write the old LB1[col] to LB2[col].
REQ-019 Per accepted pixel, SHALL shift column {LB2[col], LB1[col], pix_in} (top to bottom) into a 3-column shift register; the newest column becomes c=2.
REQ-020 Column wrap: when col = wreg-1, col SHALL go to 0 and row SHALL increment; row SHALL saturate at 16'hFFFF.
REQ-021 win_valid SHALL pulse for exactly one cycle, 1 clk after acceptance of pixel (x,y), iff x >= 2 and y >= 2, with cx = x-1 and cy = y-1.
REQ-022 Border pixels (row/column 0 and wreg-1) SHALL produce no window; output size is (wreg-2) x (rows-2).
REQ-023 win, cx and cy SHALL be registered and SHALL hold their values when win_valid=0.
REQ-024 Gaps in pix_valid SHALL stall counters and shift register without losing state; output timing is relative to acceptance only.
REQ-025 sof and pix_valid in the same cycle: that pixel SHALL be (0,0) of the new frame, using the newly latched width.
REQ-026 sof mid-frame SHALL abandon the current frame; line buffers need not be cleared because win_valid gating (REQ-021) prevents stale data from being output.
REQ-027 Pixels before the first sof after reset SHALL be ignored.

Reset
REQ-028 rstn=0 SHALL immediately clear col, row, wreg, shift register, win, cx, cy, win_valid; cfg_err SHALL reset to 1 until the first valid sof.
REQ-029 Line-buffer RAM contents SHALL NOT need reset.
REQ-030 Reset asserted mid-frame SHALL drop win_valid the same cycle; the block SHALL resume only after the next sof.

Verification
REQ-031 sof with width=4, then pixels 1..12 back-to-back -> exactly two windows: (cx,cy)=(1,1) with k0..k8 = 1,2,3,5,6,7,9,10,11, then (2,1) with 2,3,4,6,7,8,10,11,12; each 1 clk after pixels 11 and 12.
REQ-032 Same frame with pix_valid low on every other cycle -> identical windows and values; each win_valid 1 clk after its accepting cycle.
REQ-033 sof with width=2, and sof with width=MAX_WIDTH+1, each followed by 20 pixels -> cfg_err=1, win_valid never asserts.
REQ-034 width=4 frame interrupted after 7 pixels by sof (width=3) plus 9 pixels 0x10..0x18 -> one window (1,1) = 0x10..0x18; no window mixes data from both frames.
REQ-035 rstn pulsed low after 10 pixels -> all outputs 0 in the same cycle; pixels before the next sof are ignored; the following width=4 frame reproduces the REQ-031 result.
REQ-036 width=MAX_WIDTH, 3 rows of ramp data (pixel = col mod 256) -> MAX_WIDTH-2 windows; last window has cx=MAX_WIDTH-2 and no wrap corruption.

Source files
------------

// File: rtl/line_window3x3.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two line buffers supply rows y-1 and y-2 beside the incoming pixel.
module line_window3x3 #(
  parameter int MAX_WIDTH = 640,
  parameter int ADDR_W    = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] width,
  input  logic        sof,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic [71:0] win,
  output logic        win_valid,
  output logic [15:0] cx,
  output logic [15:0] cy,
  output logic        cfg_err
);

  localparam logic [15:0] MAX_W = 16'(MAX_WIDTH);

  logic [15:0]       wreg_r;
  logic [15:0]       col_r;
  logic [15:0]       row_r;
  logic              cfg_err_r;
  logic [2:0][23:0]  sh_r;
  logic [71:0]       win_r;
  logic              win_valid_r;
  logic [15:0]       cx_r;
  logic [15:0]       cy_r;

  logic [7:0]        lb1_r [MAX_WIDTH];
  logic [7:0]        lb2_r [MAX_WIDTH];

  logic              new_err_s;
  logic              acc_s;
  logic [15:0]       col_use_s;
  logic [15:0]       row_use_s;
  logic [15:0]       wlim_s;
  logic [ADDR_W-1:0] addr_s;
  logic [7:0]        rd1_s;
  logic [7:0]        rd2_s;
  logic [2:0][23:0]  sh_nxt_s;
  logic [71:0]       win_nxt_s;
  logic              last_s;
  logic              emit_s;

  // Effective position and width for this cycle; sof overrides the registered state.
  always_comb begin
    new_err_s = (width < 16'd3) || (width > MAX_W);
    if (sof) begin
      acc_s     = pix_valid && !new_err_s;
      col_use_s = 16'd0;
      row_use_s = 16'd0;
      wlim_s    = width;
    end else begin
      acc_s     = pix_valid && !cfg_err_r;
      col_use_s = col_r;
      row_use_s = row_r;
      wlim_s    = wreg_r;
    end
    addr_s = col_use_s[ADDR_W-1:0];
    last_s = (col_use_s == (wlim_s - 16'd1));
    emit_s = acc_s && (col_use_s >= 16'd2) && (row_use_s >= 16'd2);
  end

  // Line-buffer read, next shift-register content and the window it forms.
  always_comb begin
    rd1_s     = lb1_r[addr_s];
    rd2_s     = lb2_r[addr_s];
    // Columns are packed {top, middle, bottom}; index 2 holds the newest column.
    sh_nxt_s  = {{rd2_s, rd1_s, pix_in}, sh_r[2], sh_r[1]};
    win_nxt_s = 72'h0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_nxt_s[8*(3*r+c) +: 8] = sh_nxt_s[c][8*(2-r) +: 8];
      end
    end
  end

  // Line-buffer RAMs: the displaced row y-1 pixel moves down to the y-2 buffer.
  always_ff @(posedge clk) begin
    if (acc_s) begin
      lb1_r[addr_s] <= pix_in;
      lb2_r[addr_s] <= rd1_s;
    end
  end

  // Frame configuration, raster counters and column shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wreg_r    <= 16'd0;
      cfg_err_r <= 1'b1;
      col_r     <= 16'd0;
      row_r     <= 16'd0;
      sh_r      <= '0;
    end else begin
      if (sof) begin
        wreg_r    <= width;
        cfg_err_r <= new_err_s;
      end
      if (acc_s) begin
        sh_r <= sh_nxt_s;
        if (last_s) begin
          col_r <= 16'd0;
          row_r <= (row_use_s == 16'hFFFF) ? 16'hFFFF : row_use_s + 16'd1;
        end else begin
          col_r <= col_use_s + 16'd1;
          row_r <= row_use_s;
        end
      end else if (sof) begin
        col_r <= 16'd0;
        row_r <= 16'd0;
      end
    end
  end

  // Registered window outputs; values hold between windows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_r       <= 72'h0;
      win_valid_r <= 1'b0;
      cx_r        <= 16'd0;
      cy_r        <= 16'd0;
    end else begin
      win_valid_r <= emit_s;
      if (emit_s) begin
        win_r <= win_nxt_s;
        cx_r  <= col_use_s - 16'd1;
        cy_r  <= row_use_s - 16'd1;
      end
    end
  end

  assign win       = win_r;
  assign win_valid = win_valid_r;
  assign cx        = cx_r;
  assign cy        = cy_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_line_window3x3.sv
// Randomized and directed bench for line_window3x3 against a whole-frame image model.
module tb_line_window3x3;

  localparam int MAXW = 640;

  logic        clk;
  logic        rstn;
  logic [15:0] width;
  logic        sof;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic [71:0] win;
  logic        win_valid;
  logic [15:0] cx;
  logic [15:0] cy;
  logic        cfg_err;

  line_window3x3 #(.MAX_WIDTH(MAXW), .ADDR_W(10)) dut (
    .clk(clk), .rstn(rstn), .width(width), .sof(sof), .pix_in(pix_in),
    .pix_valid(pix_valid), .win(win), .win_valid(win_valid), .cx(cx),
    .cy(cy), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: the current frame as an image keyed by (x,y).
  int          img [int];
  int          m_w;
  int          m_col;
  int          m_row;
  logic        m_err;
  logic        exp_valid;
  logic [71:0] exp_win;
  logic [15:0] exp_cx;
  logic [15:0] exp_cy;
  int          dut_wins;

  function automatic int key(input int x, input int y);
    return y * 65536 + x;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    img.delete();
    m_w = 0; m_col = 0; m_row = 0; m_err = 1'b1;
    exp_valid = 1'b0; exp_win = 72'h0; exp_cx = 16'd0; exp_cy = 16'd0;
  endtask

  task automatic model_step(input logic s, input logic [15:0] w, input logic v, input logic [7:0] p);
    if (s) begin
      m_w = int'(w);
      m_err = (m_w < 3) || (m_w > MAXW);
      m_col = 0; m_row = 0;
      img.delete();
    end
    exp_valid = 1'b0;
    if (v && !m_err) begin
      img[key(m_col, m_row)] = int'(p);
      if (m_col >= 2 && m_row >= 2) begin
        exp_valid = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_win[8*(3*r+c) +: 8] = 8'(img[key(m_col-2+c, m_row-2+r)]);
        exp_cx = 16'(m_col - 1);
        exp_cy = 16'(m_row - 1);
      end
      m_col++;
      if (m_col == m_w) begin
        m_col = 0;
        if (m_row < 65535) m_row++;
      end
    end
  endtask

  // One clock: drive, update model, then sample 1 time unit after the edge.
  task automatic cycle(input logic s, input logic [15:0] w, input logic v, input logic [7:0] p);
    sof = s; width = w; pix_valid = v; pix_in = p;
    model_step(s, w, v, p);
    @(posedge clk);
    #1;
    if (win_valid) dut_wins++;
    chk("win_valid", 72'(win_valid), 72'(exp_valid));
    chk("cfg_err", 72'(cfg_err), 72'(m_err));
    chk("win", win, exp_win);
    chk("cx", 72'(cx), 72'(exp_cx));
    chk("cy", 72'(cy), 72'(exp_cy));
  endtask

  task automatic pulse_reset();
    sof = 1'b0; pix_valid = 1'b0;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_win", win, 72'd0);
    chk("rst_cx", 72'(cx), 72'd0);
    chk("rst_cy", 72'(cy), 72'd0);
    chk("rst_cfg_err", 72'(cfg_err), 72'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Frame of width 4 with pixels 1..12; gap inserts an idle cycle between pixels.
  task automatic frame4(input logic gap);
    dut_wins = 0;
    cycle(1'b1, 16'd4, 1'b0, 8'd0);
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 16'd4, 1'b1, 8'(i));
      if (gap) cycle(1'b0, 16'd4, 1'b0, 8'hEE);
    end
    cycle(1'b0, 16'd4, 1'b0, 8'd0);
    chk("f4_count", 72'(dut_wins), 72'd2);
    chk("f4_last_win", win, 72'h0C0B0A080706040302);
    chk("f4_last_cx", 72'(cx), 72'd2);
    chk("f4_last_cy", 72'(cy), 72'd1);
  endtask

  initial begin
    rstn = 1'b0; sof = 1'b0; width = 16'd0; pix_in = 8'd0; pix_valid = 1'b0;
    dut_wins = 0;
    model_reset();
    #12;
    chk("reset_valid", 72'(win_valid), 72'd0);
    chk("reset_cfg_err", 72'(cfg_err), 72'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Pixels before any sof are ignored.
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'd4, 1'b1, 8'(i + 40));

    // Back-to-back frame, first window checked explicitly.
    dut_wins = 0;
    cycle(1'b1, 16'd4, 1'b0, 8'd0);
    for (int i = 1; i <= 11; i++) cycle(1'b0, 16'd4, 1'b1, 8'(i));
    chk("f4_first_win", win, 72'h0B0A09070605030201);
    chk("f4_first_cx", 72'(cx), 72'd1);
    chk("f4_first_cy", 72'(cy), 72'd1);
    cycle(1'b0, 16'd4, 1'b1, 8'd12);
    cycle(1'b0, 16'd4, 1'b0, 8'd0);
    chk("f4_first_count", 72'(dut_wins), 72'd2);

    frame4(1'b1);

    // Unusable widths.
    for (int t = 0; t < 2; t++) begin
      dut_wins = 0;
      cycle(1'b1, (t == 0) ? 16'd2 : 16'(MAXW + 1), 1'b1, 8'd1);
      for (int i = 0; i < 20; i++) cycle(1'b0, 16'd0, 1'b1, 8'($urandom));
      chk("bad_w_count", 72'(dut_wins), 72'd0);
      chk("bad_w_err", 72'(cfg_err), 72'd1);
    end

    // Frame abandoned by a new sof carrying its first pixel.
    cycle(1'b1, 16'd4, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 16'd4, 1'b1, 8'(i + 100));
    dut_wins = 0;
    cycle(1'b1, 16'd3, 1'b1, 8'h10);
    for (int i = 1; i < 9; i++) cycle(1'b0, 16'd3, 1'b1, 8'(16 + i));
    cycle(1'b0, 16'd3, 1'b0, 8'd0);
    chk("abort_count", 72'(dut_wins), 72'd1);
    chk("abort_win", win, 72'h181716151413121110);

    // Reset mid-frame, stray pixels, then a clean frame.
    cycle(1'b1, 16'd4, 1'b0, 8'd0);
    for (int i = 1; i <= 10; i++) cycle(1'b0, 16'd4, 1'b1, 8'(i + 50));
    pulse_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 16'd4, 1'b1, 8'(i + 70));
    frame4(1'b0);

    // Full-width ramp, three rows.
    dut_wins = 0;
    cycle(1'b1, 16'(MAXW), 1'b0, 8'd0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < MAXW; c++) cycle(1'b0, 16'(MAXW), 1'b1, 8'(c % 256));
    cycle(1'b0, 16'(MAXW), 1'b0, 8'd0);
    chk("ramp_count", 72'(dut_wins), 72'(MAXW - 2));
    chk("ramp_last_cx", 72'(cx), 72'(MAXW - 2));
    chk("ramp_last_cy", 72'(cy), 72'd1);

    // Random frames: random width, gaps, sof with pixel, occasional abort.
    for (int f = 0; f < 12; f++) begin
      int w, rows, n, abort_at;
      logic s_with_pix;
      w = $urandom_range(3, 12);
      rows = $urandom_range(3, 6);
      n = w * rows;
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : n;
      s_with_pix = 1'($urandom_range(0, 1));
      cycle(1'b1, 16'(w), s_with_pix, 8'($urandom));
      for (int i = (s_with_pix ? 1 : 0); i < abort_at; i++) begin
        while ($urandom_range(0, 2) == 0) cycle(1'b0, 16'($urandom), 1'b0, 8'($urandom));
        cycle(1'b0, 16'($urandom), 1'b1, 8'($urandom));
      end
      cycle(1'b0, 16'd0, 1'b0, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
